// File: rtl/ahb_apb_bridge_mp.sv
// AHB-to-APB bridge with a decoded one-hot select over NUM_SLV APB targets.
// APB wait states stretch HREADYOUT; slave errors become a two-cycle AHB ERROR.
module ahb_apb_bridge_mp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12,
    parameter int IDX_W   = 2
) (
    input  logic                      Hclk,
    input  logic                      Hrstn,
    input  logic                      Hsel_APB,
    input  logic [1:0]                Htrans,
    input  logic                      Hwrite,
    input  logic                      Hready_in,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    output logic                      Hready_out,
    output logic [1:0]                Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata,
    output logic                      Pwrite,
    output logic [NUM_SLV-1:0]        Pselx,
    output logic                      Penable,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    // NUM_SLV fits in IDX_W+1 bits because 2**IDX_W >= NUM_SLV.
    localparam logic [IDX_W:0] NUM_SLV_L = (IDX_W + 1)'(NUM_SLV);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                valid;
    logic [IDX_W-1:0]    h_idx;
    logic                h_oor;
    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   prdata_sel;
    logic                done_ok;
    logic                accept_ok;
    logic                unused_htrans0;

    assign unused_htrans0 = Htrans[0];

    assign valid = Hsel_APB & Htrans[1] & Hready_in;
    assign h_idx = Haddr[SLV_LSB +: IDX_W];
    assign h_oor = ({1'b0, h_idx} >= NUM_SLV_L);

    // Mux the response of the currently addressed slave only.
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pready_sel  = Pready[i];
                pslverr_sel = Pslverr[i];
                prdata_sel  = Prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign done_ok   = (state_q == S_ACCESS) & pready_sel & ~pslverr_sel;
    assign accept_ok = (state_q == S_IDLE) | (state_q == S_ERR2) | done_ok;

    // Next-state and next-register computation; acceptance overrides the
    // per-state transition when the bridge is ready for a new address phase.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        case (state_q)
            S_WWAIT: begin
                pwdata_d = Hwdata;
                state_d  = S_SETUP;
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready_sel && pslverr_sel) begin
                    state_d = S_ERR1;
                end
            end
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = state_q;
        endcase
        if (accept_ok) begin
            if (valid) begin
                paddr_d  = Haddr;
                pwrite_d = Hwrite;
                idx_d    = h_idx;
                if (h_oor) begin
                    state_d = S_ERR1;
                end else if (Hwrite) begin
                    state_d = S_WWAIT;
                end else begin
                    state_d = S_SETUP;
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // State and APB-side registers; reset aborts any transfer in flight.
    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
        end
    end

    // One-hot select driven only while an APB access is in progress.
    always_comb begin
        Pselx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            Pselx[i] = ((state_q == S_SETUP) || (state_q == S_ACCESS))
                       && (idx_q == IDX_W'(i));
        end
    end

    assign Penable    = (state_q == S_ACCESS);
    assign Paddr      = paddr_q;
    assign Pwdata     = pwdata_q;
    assign Pwrite     = pwrite_q;
    assign Hready_out = (state_q == S_IDLE) | (state_q == S_ERR2) | done_ok;
    assign Hresp      = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01
                                                                      : 2'b00;
    assign Hrdata     = (done_ok && !pwrite_q) ? prdata_sel : '0;

endmodule

// File: doc/ahb_apb_bridge_mp.md
Name: ahb_apb_bridge_mp

Overview:
Parametrised AHB-to-APB bridge with multiple APB targets. Decodes the target from an address field and drives a one-hot Pselx vector. Supports APB wait states (Pready) and slave errors (Pslverr), mapped to the AHB two-cycle ERROR response. Sits between the AHB interconnect (selected by Hsel_APB) and up to NUM_SLV APB peripherals.

Parameters:
ADDR_W, 32, address width of Haddr and Paddr
DATA_W, 32, data width of all data buses
NUM_SLV, 4, number of APB targets (1..16)
SLV_LSB, 12, LSB of the slave-index field in Haddr
IDX_W, 2, width of the slave-index field; must satisfy 2**IDX_W >= NUM_SLV

Ports:
Hclk  in  1  clock; all logic on the rising edge
Hrstn  in  1  asynchronous active-low reset
Hsel_APB  in  1  AHB select for this bridge
Htrans  in  2  AHB transfer type
Hwrite  in  1  AHB direction, 1 = write
Hready_in  in  1  AHB bus HREADY, qualifies the address phase
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data, valid in the data phase
Hready_out  out  1  bridge HREADYOUT
Hresp  out  2  00 = OKAY, 01 = ERROR
Hrdata  out  DATA_W  read data to AHB
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Pwrite  out  1  APB direction
Pselx  out  NUM_SLV  one-hot APB select
Penable  out  1  APB enable
Prdata  in  NUM_SLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
Pready  in  NUM_SLV  per-slave ready
Pslverr  in  NUM_SLV  per-slave error

Behaviour:
- Valid = Hsel_APB & Htrans[1] & Hready_in. NONSEQ and SEQ are accepted; IDLE and BUSY are ignored.
- idx = Haddr[SLV_LSB +: IDX_W], captured together with Haddr and Hwrite on acceptance.
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2. Encoding is free.
- Acceptance (IDLE, ERR2, or ACCESS on its completing cycle), when Valid:
  - register Paddr <= Haddr, Pwrite <= Hwrite, idx.
  - If idx >= NUM_SLV, go to ERR1; no APB access occurs.
  - Otherwise go to WWAIT if Hwrite = 1, else SETUP.
  - Without Valid, go to IDLE.
- IDLE: Hready_out=1, Hresp=00, Pselx=0, Penable=0.
- WWAIT: Hready_out=0; Pwdata <= Hwdata; go to SETUP.
- SETUP: Pselx[idx]=1, Penable=0, Hready_out=0; go to ACCESS.
- ACCESS: Pselx[idx]=1, Penable=1.
  - Pready[idx]=0: stay in ACCESS, Hready_out=0, all APB outputs held stable.
  - Pready[idx]=1 and Pslverr[idx]=0: Hready_out=1, Hresp=00. On a read, Hrdata = Prdata slice idx in this cycle. Acceptance rules apply (back-to-back transfers allowed).
  - Pready[idx]=1 and Pslverr[idx]=1: go to ERR1, Hready_out=0.
- ERR1: Hresp=01, Hready_out=0, Pselx=0, Penable=0; go to ERR2.
- ERR2: Hresp=01, Hready_out=1; acceptance rules apply.
- Pselx and Penable are 0 in every state except SETUP/ACCESS. Only bit idx of Pselx may ever be set.
- Hrdata = 0 whenever it is not a completing read cycle.
- Paddr, Pwdata and Pwrite hold their last value between transfers.
- Pready/Pslverr from unselected slaves are ignored.
- Latency from address-phase acceptance to Hready_out=1:
  - read: 2 cycles plus APB wait states;
  - write: 3 cycles plus APB wait states;
  - out-of-range: ERROR response in the 2 cycles after acceptance.
- Reset (asynchronous, any state, including mid-ACCESS): state=IDLE; Paddr=0, Pwdata=0, Pwrite=0, Pselx=0, Penable=0, Hready_out=1, Hresp=00, Hrdata=0. No completion is signalled for an aborted transfer.

Test Plan:
1. Read, slave 1, Haddr=0x0000_1010, Pready=1, Prdata slice 1=0xDEAD_BEEF -> Pselx=0010 at T+1 (SETUP); Penable=1 and Hready_out=1 with Hrdata=0xDEAD_BEEF at T+2.
2. Write 0xA5A5_0001 to slave 2 (Haddr=0x2004), Pready low for 2 ACCESS cycles -> Pwdata=0xA5A5_0001 from SETUP onward, Penable=1 for 3 cycles, Hready_out=1 only on the final cycle.
3. Back-to-back read of 0x0000, then write to 0x3008 presented on the read's completing cycle -> no IDLE gap; WWAIT follows directly; Pselx switches 0001 -> 1000.
4. Read of slave 0 with Pslverr=1, Pready=1 -> ERR1 (Hresp=01, Hready_out=0), then ERR2 (Hresp=01, Hready_out=1), then IDLE.
5. NUM_SLV=3, Haddr=0x3000 -> no Pselx asserted; two-cycle ERROR response.
6. Hrstn low during ACCESS with Pready=0 -> Pselx=0, Penable=0, Hready_out=1 immediately (asynchronously); after release, a new read completes normally.
